// File: rtl/spectrum_stream_pkg.sv
// Shared types and constants for the spectrum frame streamer: state encoding,
// sample width and the default frame sync word.
package spectrum_stream_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] SYNC_WORD_DEFAULT = 16'hAA55;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

endpackage

// File: rtl/frame_buf.sv
// Simple dual-port frame buffer: one write port, one registered read port
// (one-cycle read latency). Contents are not reset.
module frame_buf
  import spectrum_stream_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spectrum_frame_streamer.sv
// Buffers one frame of spectrum samples, then replays it word-by-word to the UART
// sender with a fixed handle-to-handle gap. Define FRAME_HEADER_EN to prefix each frame with SYNC_WORD and its word count.
module spectrum_frame_streamer
  import spectrum_stream_pkg::*;
#(
  parameter int                DEPTH      = 64,
  parameter int                GAP_CYCLES = 10000,
  parameter logic [DATA_W-1:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] data,
  output logic              handle,
  output logic              busy,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_TERM   = GW'(GAP_CYCLES - 2);
  // Leaving GAP on the cycle the counter steps onto its terminal value gives
  // GAP_CYCLES-2 GAP cycles; with SEND and LOAD/HDR that spaces handles GAP_CYCLES apart.
  localparam logic [GW-1:0] GAP_EXIT   = GW'(GAP_CYCLES - 3);

`ifdef FRAME_HEADER_EN
  localparam state_t ST_AFTER_CLOSE = ST_HDR;
`else
  localparam state_t ST_AFTER_CLOSE = ST_LOAD;
`endif

  state_t            state, state_nxt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [GW-1:0]     gap_cnt;
  logic              rd_last;
  logic              accept, close_frame, gap_done, frame_done;
  logic              more_hdr;
  logic [DATA_W-1:0] hdr_word;
  logic [DATA_W-1:0] rd_data_p1;
  logic [AW-1:0]     last_ptr;

  assign in_ready    = (state == ST_FILL);
  assign busy        = (state != ST_FILL);
  assign accept      = in_valid && in_ready;
  assign close_frame = accept && (in_last || (count == COUNT_LAST));
  assign gap_done    = (gap_cnt == GAP_EXIT);
  assign last_ptr    = AW'(count - CW'(1));

  frame_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_frame_buf (
    .sys_clk (sys_clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (state == ST_LOAD),
    .rd_addr (rd_ptr),
    .rd_data (rd_data_p1)
  );

`ifdef FRAME_HEADER_EN
  logic [1:0] hdr_cnt;

  assign more_hdr = (hdr_cnt != 2'd2);
  assign hdr_word = (hdr_cnt == 2'd0) ? SYNC_WORD : DATA_W'(count);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt <= 2'd0;
    end else if (state == ST_SEND && more_hdr) begin
      hdr_cnt <= hdr_cnt + 2'd1;
    end else if (frame_done) begin
      hdr_cnt <= 2'd0;
    end
  end
`else
  assign more_hdr = 1'b0;
  assign hdr_word = '0;
`endif

  assign frame_done = (state == ST_GAP) && gap_done && !more_hdr && rd_last;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL: if (close_frame) state_nxt = ST_AFTER_CLOSE;
      ST_HDR:  state_nxt = ST_SEND;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_GAP;
      ST_GAP: begin
        if (gap_done) begin
          if (more_hdr)     state_nxt = ST_HDR;
          else if (rd_last) state_nxt = ST_FILL;
          else              state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      gap_cnt  <= '0;
      rd_last  <= 1'b0;
      overflow <= 1'b0;
      handle   <= 1'b0;
      data     <= '0;
    end else begin
      state  <= state_nxt;
      handle <= (state == ST_SEND);

      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end

      // A sample arriving while the buffer holds a full frame is dropped and flagged.
      if (accept && count == '0)
        overflow <= 1'b0;
      else if (in_valid && count == COUNT_FULL)
        overflow <= 1'b1;

      if (state == ST_SEND) begin
        gap_cnt <= '0;
        if (more_hdr) begin
          data <= hdr_word;
        end else begin
          data    <= rd_data_p1;
          rd_ptr  <= rd_ptr + AW'(1);
          rd_last <= (rd_ptr == last_ptr);
        end
      end else if (state == ST_GAP && gap_cnt != GAP_TERM) begin
        gap_cnt <= gap_cnt + GW'(1);
      end

      if (frame_done) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        rd_last <= 1'b0;
      end
    end
  end

endmodule
